// File: rtl/bp_fetch_unit_pkg.sv
// Shared types and helpers for the fetch unit and its branch target buffer.
package bp_fetch_unit_pkg;

    // 2-bit saturating direction counter; the upper bit is the prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Per-entry BTB state. Tag and target widths follow the module
    // parameters, so those fields live in parallel arrays inside btb_dm.
    typedef struct packed {
        logic valid;
        ctr_e ctr;
    } btb_state_t;

    function automatic ctr_e ctr_inc(input ctr_e c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return (c == CTR_WT) || (c == CTR_ST);
    endfunction

endpackage

// File: rtl/bp_fetch_unit_if.sv
// Instruction-memory, IF/ID and EX-resolution signals of the fetch unit.
interface bp_fetch_unit_if #(
    parameter int PC_W   = 18,
    parameter int DATA_W = 32
);
    // Instruction memory
    logic [PC_W-3:0]   im_addr;
    logic [DATA_W-1:0] im_instr;

    // IF/ID stage register
    logic [PC_W-1:0]   id_pc_plus4;
    logic [DATA_W-1:0] id_ir;
    logic              id_valid;
    logic              id_pred_taken;
    logic [PC_W-1:0]   id_pred_target;

    // Control-transfer resolution from EX
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_taken;
    logic [PC_W-1:0]   ex_target;
    logic              ex_pred_taken;
    logic [PC_W-1:0]   ex_pred_target;

    // Fetch-unit side
    modport master (
        output im_addr,
        input  im_instr,
        output id_pc_plus4, id_ir, id_valid, id_pred_taken, id_pred_target,
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target
    );

    // Memory / pipeline side
    modport slave (
        input  im_addr,
        output im_instr,
        input  id_pc_plus4, id_ir, id_valid, id_pred_taken, id_pred_target,
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target
    );
endinterface

// File: rtl/bp_fetch_unit_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// trained on the clock edge by EX resolutions. Works on word addresses.
module btb_dm
    import bp_fetch_unit_pkg::*;
#(
    parameter int PC_W  = 18,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-3:0] rd_word,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            wr_en,
    input  logic [PC_W-3:0] wr_word,
    input  logic            wr_taken,
    input  logic [PC_W-1:0] wr_target
);
    localparam int WORD_W = PC_W - 2;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TAG_W  = WORD_W - IDX_W;

    btb_state_t       state_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, wr_hit;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[WORD_W-1:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[WORD_W-1:IDX_W];

    // Lookup reads the pre-update contents; a same-cycle write shows next cycle.
    assign rd_hit      = state_q[rd_idx].valid && (tag_q[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && ctr_taken(state_q[rd_idx].ctr);
    assign pred_target = target_q[rd_idx];

    assign wr_hit = state_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);

    // Valid bits and direction counters: train on hit, allocate on taken miss.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= '{valid: 1'b0, ctr: CTR_WNT};
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                state_q[wr_idx].ctr <= wr_taken ? ctr_inc(state_q[wr_idx].ctr)
                                                : ctr_dec(state_q[wr_idx].ctr);
            end else if (wr_taken) begin
                state_q[wr_idx] <= '{valid: 1'b1, ctr: CTR_WT};
            end
        end
    end

    // Tag and target: written on every taken resolution (allocate or retarget).
    // NOTE: no reset on this storage; the valid bit alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/bp_fetch_unit.sv
// Fetch stage: PC register, next-PC selection with BTB prediction,
// IF/ID stage register, mispredict detection and statistics counters.
module bp_fetch_unit
    import bp_fetch_unit_pkg::*;
#(
    parameter int              PC_W      = 18,
    parameter int              DATA_W    = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    bp_fetch_unit_if.master  bus,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_plus4, ex_pc_plus4, redirect_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic [DATA_W-1:0] fetched_ir;

    assign pc_plus4    = pc_q + PC_W'(4);
    assign ex_pc_plus4 = bus.ex_pc + PC_W'(4);
    assign redirect_pc = bus.ex_taken ? bus.ex_target : ex_pc_plus4;
    assign bus.im_addr = pc_q[PC_W-1:2];
    assign fetched_ir  = bus.im_instr;

    assign mispredict = bus.ex_valid &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

    btb_dm #(
        .PC_W  (PC_W),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_word     (pc_q[PC_W-1:2]),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .wr_en       (bus.ex_valid),
        .wr_word     (bus.ex_pc[PC_W-1:2]),
        .wr_taken    (bus.ex_taken),
        .wr_target   (bus.ex_target)
    );

    // Next PC: mispredict redirect, then stall hold, then prediction, then sequential.
    // NOTE: pc_d gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_plus4;
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID register: flush on mispredict (even under stall), hold on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.id_pc_plus4    <= '0;
            bus.id_ir          <= '0;
            bus.id_valid       <= 1'b0;
            bus.id_pred_taken  <= 1'b0;
            bus.id_pred_target <= '0;
        end else if (mispredict) begin
            bus.id_pc_plus4    <= '0;
            bus.id_ir          <= '0;
            bus.id_valid       <= 1'b0;
            bus.id_pred_taken  <= 1'b0;
            bus.id_pred_target <= '0;
        end else if (!stall) begin
            bus.id_pc_plus4    <= pc_plus4;
            bus.id_ir          <= fetched_ir;
            bus.id_valid       <= 1'b1;
            bus.id_pred_taken  <= pred_taken;
            bus.id_pred_target <= pred_target;
        end
    end

    // Statistics: saturating counts of resolutions and mispredicts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (bus.ex_valid && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/bp_fetch_unit.md
Name: bp_fetch_unit

Overview:
- Parametrised successor to the fixed PC / PC+4 / IF_ID fetch path of the 5-stage pipeline core.
- Holds the PC, issues instruction-memory addresses, and registers the IF/ID stage.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps redirect in IF instead of EX.
- Branches still resolve in EX. The resolution port trains the BTB and triggers mispredict redirect and flush.

Parameters:
- PC_W, 18, PC width in bytes; instruction-memory address is PC_W-2 bits.
- DATA_W, 32, instruction width.
- BTB_DEPTH, 16, BTB entries; power of two, at least 2; IDX_W = log2(BTB_DEPTH).
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  from HDU; holds PC and IF/ID (load-use).
- im_addr  out  PC_W-2  instruction-memory word address, equal to pc[PC_W-1:2].
- im_instr  in  DATA_W  instruction at im_addr, same cycle.
- id_pc_plus4  out  PC_W  PC+4 of the instruction in ID.
- id_ir  out  DATA_W  instruction in ID.
- id_valid  out  1  ID slot holds a real instruction.
- id_pred_taken  out  1  prediction made in IF; carried down the pipe to EX.
- id_pred_target  out  PC_W  predicted target; carried down the pipe to EX.
- ex_valid  in  1  EX holds a real control-transfer instruction (branch, j, jal, jr).
- ex_pc  in  PC_W  byte address of that instruction (not +4).
- ex_taken  in  1  resolved direction; jumps are always 1.
- ex_target  in  PC_W  resolved target.
- ex_pred_taken  in  1  prediction as carried to EX.
- ex_pred_target  in  PC_W  predicted target as carried to EX.
- mispredict  out  1  combinational; flush IF/ID (internal) and ID/EX (HDU).
- branch_count  out  CNT_W  resolved control transfers.
- mispred_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; id_ir=0; id_pc_plus4=0; id_valid=0; id_pred_taken=0; id_pred_target=0.
  - All BTB valid bits 0; counters = WNT (01).
  - Both statistics counters 0.
  - Reset mid-flight discards all state; the first fetch after release is at RESET_PC.
- BTB entry fields: valid, tag = pc[PC_W-1:2+IDX_W], target[PC_W], ctr[2] (SNT=00, WNT=01, WT=10, ST=11).
  - Index = pc[2+IDX_W-1:2].
- Lookup (combinational on the current pc):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = entry target.
- Next PC, in priority order:
  - mispredict: ex_taken ? ex_target : ex_pc+4.
  - stall: pc held.
  - pred_taken: pred_target.
  - otherwise: pc+4, wrapping mod 2^PC_W.
- mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- IF/ID register, in priority order:
  - mispredict: flush (id_ir=0 (NOP), id_valid=0, pred fields 0). Mispredict overrides stall.
  - stall: hold.
  - otherwise: load {pc+4, im_instr, 1, pred_taken, pred_target}.
- BTB update on the clock edge when ex_valid, whether or not stall is asserted:
  - Hit, taken: ctr saturating increment; target=ex_target.
  - Hit, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate (replace): valid=1, tag, target=ex_target, ctr=WT.
  - Miss, not taken: no change.
- Same-cycle lookup and update on the same index: lookup sees the old contents; the update is visible next cycle.
- Statistics:
  - branch_count += ex_valid.
  - mispred_count += mispredict.
  - Both saturate at all-ones; no wrap.
- Latency: im_addr to IF/ID is 1 cycle. Mispredict penalty is 2 cycles (IF and ID slots flushed).

Decomposition:
- Shared package: 2-bit counter encodings SNT/WNT/WT/ST; saturating increment/decrement functions; BTB entry struct typedef.
- One sub-module: btb_dm (storage, lookup, update); the top holds PC, next-PC mux, IF/ID register, and statistics.

Test Plan:
- Reset, then release with stall=0, instructions A,B,C: im_addr=0,1,2 on successive cycles. id_pc_plus4=4,8,12; id_valid=0 in the first cycle.
- Branch at 0x10 resolved taken to 0x40, never seen before: mispredict=1, next pc=0x40, id_valid=0. The next fetch at 0x10 predicts taken to 0x40 (ctr=WT) with no mispredict.
- Same branch resolved not-taken twice: ctr goes WT then WNT; the next fetch at 0x10 goes to 0x14. The first not-taken resolution raises mispredict with redirect to 0x14.
- stall=1 for 2 cycles: pc and IF/ID hold their values. stall=1 together with mispredict: pc loads the redirect and IF/ID is flushed.
- Aliasing with BTB_DEPTH=4: a branch at 0x10 and a branch at 0x50 share index 0 with different tags. After allocating 0x50, a fetch at 0x10 misses and predicts not-taken.
- PC wrap: pc=2^18-4 with no prediction, so next pc=0. Force 2^CNT_W mispredicts: mispred_count holds at 0xFFFF.
